nibble_serial_addsub_seq: RTL and testbench

//  Sequencer that performs a wide (4*NIBBLES-bit) add or subtract by driving an

---
 rtl/nibble_serial_addsub_seq.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_addsub_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_seq.sv
// nibble_serial_addsub_seq: wide add/subtract sequencer driving an external
// combinational 4-bit adder slice one nibble per clock, LSB first, with the
// carry chained through a register between nibbles.
module nibble_serial_addsub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_sub,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   res,
  output logic                   res_carry,
  output logic                   res_ovf,
  output logic                   res_zero
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic            carry_q, carry_d;
  logic            sub_q,   sub_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic [W-1:0]    res_q,   res_d;
  logic            rc_q,    rc_d;
  logic            ovf_q,   ovf_d;
  logic            zero_q,  zero_d;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic            beff_msb;

  // Current operand nibbles; B is inverted here so the slice always adds.
  always_comb begin
    nib_a    = a_q[{idx_q, 2'b00} +: 4];
    nib_b    = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
    beff_msb = b_q[W-1] ^ sub_q;
  end

  // Handshake and slice-facing outputs; slice inputs are forced to zero outside RUN.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (state_q == ST_RUN) begin
      add_a   = nib_a;
      add_b   = nib_b;
      add_cin = carry_q;
    end
    res       = res_q;
    res_carry = rc_q;
    res_ovf   = ovf_q;
    res_zero  = zero_q;
  end

  // Next-state logic: operand staging, nibble capture, carry chaining and flags.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rc_d    = rc_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[{idx_q, 2'b00} +: 4] = add_s;
        carry_d = add_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDX_LAST) begin
          // Flags are taken from the final slice result in the same edge,
          // so zero is evaluated on the fully updated result word.
          idx_d   = '0;
          rc_d    = add_cout;
          ovf_d   = (a_q[W-1] == beff_msb) && (add_s[3] != a_q[W-1]);
          zero_d  = (res_d == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rc_q    <= rc_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub_seq.sv
// Testbench for nibble_serial_addsub_seq (NIBBLES=4) with a behavioural
// 4-bit slice and a word-level arithmetic reference model.
module tb_nibble_serial_addsub_seq;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_sub;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  res;
  logic          res_carry;
  logic          res_ovf;
  logic          res_zero;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  nibble_serial_addsub_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .res_zero  (res_zero)
  );

  // Combinational 4-bit adder slice.
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-level reference: plain integer arithmetic on the whole operands.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, output logic [W-1:0] r,
                                 output logic c, output logic o, output logic z);
    int sa, sb, sr;
    int unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    sr = sub ? sa - sb : sa + sb;
    r  = sub ? a - b : a + b;
    c  = sub ? (ua >= ub) : ((ua + ub) > 32'd65535);
    o  = (sr > 32767) || (sr < -32768);
    z  = (r == '0);
  endfunction

  // Issue one request, wait for the result, capture it and acknowledge.
  // lat counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] r, output logic c, output logic o,
                       output logic z, output int lat, output bit to);
    int w;
    to = 1'b0;
    w  = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) to = 1'b1;
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) to = 1'b1;
    r = res; c = res_carry; o = res_ovf; z = res_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    n_cmp++;
    if ({out_valid, res, res_carry, res_ovf, res_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ov=%b res=%h c=%b o=%b z=%b exp all 0",
               out_valid, res, res_carry, res_ovf, res_zero);
    end
    n_cmp++;
    if ({add_a, add_b, add_cin} !== 9'd0) begin
      n_fail++; $display("FAIL reset_slice got a=%h b=%h cin=%b exp 0", add_a, add_b, add_cin);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h1234, 16'h0005, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234};
    logic [W-1:0] tb [6] = '{16'h0FFF, 16'h0007, 16'h0001, 16'h0001, 16'h0001, 16'h1234};
    logic         ts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] er [6] = '{16'h2233, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
    logic [2:0]   ef [6] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b101, 3'b101}; // {carry,ovf,zero}
    logic [W-1:0] r;
    logic c, o, z;
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], ts[i], r, c, o, z, lat, to);
      n_cmp++;
      if (to || r !== er[i] || {c, o, z} !== ef[i]) begin
        n_fail++;
        $display("FAIL directed_%0d got res=%h cov=%b%b%b to=%0d exp res=%h cov=%b",
                 i, r, c, o, z, to, er[i], ef[i]);
      end
      n_cmp++;
      if (lat != NIB + 1) begin
        n_fail++; $display("FAIL directed_latency_%0d got=%0d exp=%0d", i, lat, NIB + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er;
    logic s, c, o, z, ec, eo, ez;
    int lat;
    bit to;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      if (i % 8 == 0) b = a;
      if (i % 8 == 1) a = 16'h8000;
      ref_op(a, b, s, er, ec, eo, ez);
      do_op(a, b, s, r, c, o, z, lat, to);
      n_cmp++;
      if (to || r !== er || c !== ec || o !== eo || z !== ez || lat != NIB + 1) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h sub=%b got res=%h c=%b o=%b z=%b lat=%0d exp res=%h c=%b o=%b z=%b lat=%0d",
                 i, a, b, s, r, c, o, z, lat, er, ec, eo, ez, NIB + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, er;
    logic ec, eo, ez;
    int w;
    a = 16'h4321; b = 16'h5678;
    ref_op(a, b, 1'b1, er, ec, eo, ez);
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    op_a = a; op_b = b; op_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    for (int i = 0; i < 10; i++) begin
      op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'b0; in_valid = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b1 || res !== er || res_carry !== ec || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d got ov=%b res=%h c=%b ir=%b exp ov=1 res=%h c=%b ir=0",
                 i, out_valid, res, res_carry, in_ready, er, ec);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    repeat (NIB + 2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_ignored_req got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r;
    logic c, o, z;
    int lat, w;
    bit to;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    op_a = 16'hABCD; op_b = 16'h1111; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (add_a !== 4'hB || add_b !== 4'h1) begin
      n_fail++; $display("FAIL run_nibble2 got a=%h b=%h exp a=b b=1", add_a, add_b);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || res !== '0 || {add_a, add_b, add_cin} !== 9'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort got ov=%b res=%h a=%h b=%h cin=%b ir=%b exp all 0",
               out_valid, res, add_a, add_b, add_cin, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(16'h0001, 16'h0001, 1'b0, r, c, o, z, lat, to);
    n_cmp++;
    if (to || r !== 16'h0002 || {c, o, z} !== 3'b000) begin
      n_fail++; $display("FAIL after_reset_op got res=%h cov=%b%b%b exp res=0002 cov=000", r, c, o, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [2], b [2], er [2];
    logic s [2], ec, eo, ez;
    int acc_t [$];
    logic [W-1:0] got [$];
    int n;
    bit fire;
    for (int i = 0; i < 2; i++) begin
      a[i] = W'($urandom); b[i] = W'($urandom); s[i] = 1'($urandom);
      ref_op(a[i], b[i], s[i], er[i], ec, eo, ez);
    end
    n = 0;
    out_ready = 1'b1;
    op_a = a[0]; op_b = b[0]; op_sub = s[0]; in_valid = 1'b1;
    for (int c = 0; c < 60 && got.size() < 2; c++) begin
      fire = in_ready && in_valid;
      if (out_valid && out_ready) got.push_back(res);
      @(posedge clk); #1;
      if (fire) begin
        acc_t.push_back(cyc);
        n++;
        if (n < 2) begin
          op_a = a[n]; op_b = b[n]; op_sub = s[n];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (acc_t.size() != 2 || got.size() != 2) begin
      n_fail++; $display("FAIL b2b_count got acc=%0d res=%0d exp 2 2", acc_t.size(), got.size());
    end else begin
      n_cmp++;
      if (acc_t[1] - acc_t[0] != NIB + 2) begin
        n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc_t[1] - acc_t[0], NIB + 2);
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (got[i] !== er[i]) begin
          n_fail++; $display("FAIL b2b_res_%0d got=%h exp=%h", i, got[i], er[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
